input_feed_scheduler: RTL and testbench

- Sequences the systolic array's skewed input buffer chain.
- Accepts a job: `cfg_tiles` tiles, each `cfg_len` activation words long.
- Drives the row-0 read strobe. The buffer chain's own valid shift register skews the reads for rows 1..SYS_ROWS-1.
- Waits for the skew to drain after each tile and reports tile and job completion to the top-level control FSM.

---
 rtl/input_feed_scheduler.sv | 155 +++++++++++++++
 tb/tb_input_feed_scheduler.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/input_feed_scheduler.sv
// Row-0 read sequencer for the systolic input skew chain; optional stall counter under FEED_PERF_CNT_EN.
// read follows array_ready with no delay; a stall freezes counters, while DRAIN runs regardless of array_ready.
module input_feed_scheduler #(
    parameter int SYS_ROWS = 4,
    parameter int LEN_W    = 16,
    parameter int TILE_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [LEN_W-1:0]  cfg_len,
    input  logic [TILE_W-1:0] cfg_tiles,
    input  logic              array_ready,
    output logic              read,
    output logic              busy,
    output logic              tile_done,
    output logic [TILE_W-1:0] tile_idx,
    output logic              done,
    output logic              cfg_err,
    output logic [31:0]       stall_cycles
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_STREAM,
        S_DRAIN,
        S_DONE
    } state_t;

    // With one or two rows the skew chain needs only a single drain cycle.
    localparam logic [15:0] DRAIN_LAST = (SYS_ROWS > 2) ? 16'(SYS_ROWS - 2) : 16'd0;

    state_t            state_q, state_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [TILE_W-1:0] tiles_q, tiles_d;
    logic [LEN_W-1:0]  word_cnt_q, word_cnt_d;
    logic [15:0]       drain_cnt_q, drain_cnt_d;
    logic [TILE_W-1:0] tile_idx_q, tile_idx_d;
    logic              busy_q, busy_d;
    logic              cfg_err_q, cfg_err_d;
    logic              start_ok;
    logic              drain_end;

    assign read      = (state_q == S_STREAM) && array_ready;
    assign drain_end = (state_q == S_DRAIN) && (drain_cnt_q == DRAIN_LAST);
    assign start_ok  = (state_q == S_IDLE) && start && (cfg_len != '0) && (cfg_tiles != '0);

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        tiles_d     = tiles_q;
        word_cnt_d  = word_cnt_q;
        drain_cnt_d = drain_cnt_q;
        tile_idx_d  = tile_idx_q;
        cfg_err_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if ((cfg_len == '0) || (cfg_tiles == '0)) begin
                        cfg_err_d = 1'b1;
                    end else begin
                        len_d      = cfg_len;
                        tiles_d    = cfg_tiles;
                        word_cnt_d = '0;
                        tile_idx_d = '0;
                        state_d    = S_STREAM;
                    end
                end
            end
            S_STREAM: begin
                if (read) begin
                    if (word_cnt_q == len_q - LEN_W'(1)) begin
                        drain_cnt_d = '0;
                        state_d     = S_DRAIN;
                    end else begin
                        word_cnt_d = word_cnt_q + LEN_W'(1);
                    end
                end
            end
            S_DRAIN: begin
                drain_cnt_d = drain_cnt_q + 16'd1;
                if (drain_end) begin
                    if (tile_idx_q == tiles_q - TILE_W'(1)) begin
                        state_d = S_DONE;
                    end else begin
                        tile_idx_d = tile_idx_q + TILE_W'(1);
                        word_cnt_d = '0;
                        state_d    = S_STREAM;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            len_q       <= '0;
            tiles_q     <= '0;
            word_cnt_q  <= '0;
            drain_cnt_q <= '0;
            tile_idx_q  <= '0;
            busy_q      <= 1'b0;
            cfg_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            tiles_q     <= tiles_d;
            word_cnt_q  <= word_cnt_d;
            drain_cnt_q <= drain_cnt_d;
            tile_idx_q  <= tile_idx_d;
            busy_q      <= busy_d;
            cfg_err_q   <= cfg_err_d;
        end
    end

`ifdef FEED_PERF_CNT_EN
    logic [31:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (start_ok) begin
            stall_d = '0;
        end else if ((state_q == S_STREAM) && !array_ready && (stall_q != 32'hFFFF_FFFF)) begin
            stall_d = stall_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cycles = stall_q;
`else
    assign stall_cycles = 32'd0;
`endif

    assign busy      = busy_q;
    assign tile_done = drain_end;
    assign tile_idx  = tile_idx_q;
    assign done      = (state_q == S_DONE);
    assign cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_input_feed_scheduler.sv
// Bench for input_feed_scheduler: expected per-cycle outputs come from a tile schedule built from the job rules.
module tb_input_feed_scheduler;

    localparam int SYS_ROWS = 4;
    localparam int LEN_W    = 16;
    localparam int TILE_W   = 8;
    localparam int DRAIN    = (SYS_ROWS > 1) ? SYS_ROWS - 1 : 1;
    localparam int MAXC     = 512;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [LEN_W-1:0]  cfg_len;
    logic [TILE_W-1:0] cfg_tiles;
    logic              array_ready;
    logic              read;
    logic              busy;
    logic              tile_done;
    logic [TILE_W-1:0] tile_idx;
    logic              done;
    logic              cfg_err;
    logic [31:0]       stall_cycles;

    int tests = 0;
    int fails = 0;

    logic rdy_tab  [0:MAXC-1];
    logic exp_read [0:MAXC-1];
    logic exp_td   [0:MAXC-1];
    logic exp_done [0:MAXC-1];
    int   exp_idx  [0:MAXC-1];

    input_feed_scheduler #(.SYS_ROWS(SYS_ROWS), .LEN_W(LEN_W), .TILE_W(TILE_W)) dut (
        .clk(clk), .rst(rst), .start(start), .cfg_len(cfg_len), .cfg_tiles(cfg_tiles),
        .array_ready(array_ready), .read(read), .busy(busy), .tile_done(tile_done),
        .tile_idx(tile_idx), .done(done), .cfg_err(cfg_err), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // mode 0: always ready; 1: random stalls; 2: stall on cycles 2-3 only.
    // reinj pulses extra starts while busy and in the done cycle.
    task automatic run_job(input int len, input int tiles, input int mode, input bit reinj);
        int c;
        int n;
        int done_c;
        int stalls;
        for (int i = 0; i < MAXC; i++) begin
            case (mode)
                1:       rdy_tab[i] = (i >= 200) ? 1'b1 : ($urandom_range(0, 9) < 7);
                2:       rdy_tab[i] = !(i == 2 || i == 3);
                default: rdy_tab[i] = 1'b1;
            endcase
            exp_read[i] = 1'b0;
            exp_td[i]   = 1'b0;
            exp_done[i] = 1'b0;
            exp_idx[i]  = 0;
        end
        // A tile takes the first len ready cycles after it begins, then a fixed drain.
        c = 1;
        stalls = 0;
        for (int t = 0; t < tiles; t++) begin
            n = 0;
            while (n < len) begin
                exp_idx[c] = t;
                if (rdy_tab[c]) begin
                    exp_read[c] = 1'b1;
                    n++;
                end else begin
                    stalls++;
                end
                c++;
            end
            for (int d = 0; d < DRAIN; d++) begin
                exp_idx[c] = t;
                exp_td[c]  = (d == DRAIN - 1);
                c++;
            end
        end
        done_c = c;
        exp_done[done_c]    = 1'b1;
        exp_idx[done_c]     = tiles - 1;
        exp_idx[done_c + 1] = tiles - 1;

        @(posedge clk); #1;
        start       = 1'b1;
        cfg_len     = LEN_W'(len);
        cfg_tiles   = TILE_W'(tiles);
        array_ready = rdy_tab[0];
        @(negedge clk);
        chk("busy@0", busy, 0);
        chk("read@0", read, 0);
        for (int k = 1; k <= done_c + 1; k++) begin
            @(posedge clk); #1;
            start       = reinj && (k == 2 || k == done_c);
            cfg_len     = LEN_W'($urandom_range(0, 20));
            cfg_tiles   = TILE_W'($urandom_range(0, 5));
            array_ready = rdy_tab[k];
            @(negedge clk);
            chk($sformatf("read@%0d", k), read, exp_read[k]);
            chk($sformatf("tile_done@%0d", k), tile_done, exp_td[k]);
            chk($sformatf("done@%0d", k), done, exp_done[k]);
            chk($sformatf("busy@%0d", k), busy, (k <= done_c));
            chk($sformatf("tile_idx@%0d", k), tile_idx, exp_idx[k]);
            chk($sformatf("cfg_err@%0d", k), cfg_err, 0);
        end
        start = 1'b0;
`ifdef FEED_PERF_CNT_EN
        chk("stall_cycles", stall_cycles, stalls);
`else
        chk("stall_cycles", stall_cycles, 0);
`endif
    endtask

    initial begin
        rst         = 1'b1;
        start       = 1'b0;
        cfg_len     = '0;
        cfg_tiles   = '0;
        array_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_read", read, 0);
        chk("rst_busy", busy, 0);
        chk("rst_tile_done", tile_done, 0);
        chk("rst_done", done, 0);
        chk("rst_cfg_err", cfg_err, 0);
        chk("rst_tile_idx", tile_idx, 0);
        chk("rst_stall", stall_cycles, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        run_job(5, 1, 0, 1'b0);
        run_job(3, 3, 0, 1'b0);
        run_job(4, 1, 2, 1'b0);

        // Zero-length and zero-tile requests are rejected with a delayed error pulse.
        for (int e = 0; e < 2; e++) begin
            @(posedge clk); #1;
            start     = 1'b1;
            cfg_len   = (e == 0) ? LEN_W'(0) : LEN_W'(4);
            cfg_tiles = (e == 0) ? TILE_W'(2) : TILE_W'(0);
            @(negedge clk);
            chk($sformatf("err%0d_pre", e), cfg_err, 0);
            @(posedge clk); #1;
            start = 1'b0;
            @(negedge clk);
            chk($sformatf("err%0d_pulse", e), cfg_err, 1);
            chk($sformatf("err%0d_busy", e), busy, 0);
            chk($sformatf("err%0d_read", e), read, 0);
            @(posedge clk); #1;
            @(negedge clk);
            chk($sformatf("err%0d_clear", e), cfg_err, 0);
            chk($sformatf("err%0d_read2", e), read, 0);
        end

        // Reset after two reads of a six-word tile abandons the job silently.
        @(posedge clk); #1;
        start       = 1'b1;
        cfg_len     = LEN_W'(6);
        cfg_tiles   = TILE_W'(1);
        array_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        chk("mid_read1", read, 1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("mid_read2", read, 1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_read", read, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_idx", tile_idx, 0);
        chk("mid_rst_done", done, 0);
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk($sformatf("post_rst_done%0d", k), done, 0);
            chk($sformatf("post_rst_busy%0d", k), busy, 0);
        end
        run_job(6, 1, 0, 1'b0);

        run_job(3, 2, 0, 1'b1);
        run_job(4, 2, 1, 1'b1);

        for (int j = 0; j < 8; j++) begin
            run_job($urandom_range(1, 8), $urandom_range(1, 3), 1, j[0]);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
